mdu_iter: RTL
=============

# mdu_iter

Iterative multiply/divide unit for the execute stage of the pipelined MIPS core. It consumes the decoder's execute-stage mult/div controls and operands, computes MULT/MULTU/DIV/DIVU results into private HI/LO registers over multiple cycles, and serves MFHI/MFLO/MTHI/MTLO. Its busy flag is the `mdrunE` signal the controller uses to suppress HI/LO disable and to stall dependent instructions.

## Interface
- `WIDTH`, 32, operand and HI/LO width
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `mdstartE`  in  1  start a multiply/divide this cycle
- `mdopE`  in  2  bit0: 1=divide, 0=multiply; bit1: 1=unsigned, 0=signed
- `hilowriteE`  in  1  MTHI/MTLO strobe
- `hiloselE`  in  1  1=HI, 0=LO; target of MT writes and source of `hilooutE`
- `abortE`  in  1  cancel in-flight operation (exception/flush)
- `srcaE`  in  WIDTH  rs operand (dividend / multiplicand / MT data)
- `srcbE`  in  WIDTH  rt operand (divisor / multiplier)
- `mdrunE`  out  1  unit busy
- `hilooutE`  out  WIDTH  HI or LO per `hiloselE`, combinational from registers

## Operation
- States: IDLE, RUN, FIX. Reset: IDLE, HI=0, LO=0, iteration count=0, `mdrunE`=0.
- In IDLE, when `mdstartE` is sampled high, operands are latched. For signed ops, operands are converted to their absolute values and the result signs are recorded. Count is loaded to 31 and the state goes to RUN.
- In RUN, multiply uses radix-2 shift-add into a 2×WIDTH accumulator. Divide uses radix-2 restoring division: remainder shifted in from the dividend, divisor trial-subtracted, quotient bit set when the difference is non-negative. Count decrements; when count=0 the state goes to FIX.
- In FIX, the sign correction is applied:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - HI/LO are written: HI=product[63:32] or remainder, LO=product[31:0] or quotient. The state returns to IDLE.
- `mdrunE`=1 in RUN and FIX.
- Divide by zero needs no special-casing and gives a deterministic result. Unsigned: LO=0xFFFFFFFF, HI=dividend. Signed: the same magnitudes, then sign-corrected.
- Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `mdstartE` while busy is ignored (the controller stalls).
- `hilowriteE` in IDLE writes `srcaE` into HI or LO at the clock edge. While busy it is ignored.
- If `mdstartE` and `hilowriteE` are both high in IDLE, start wins and the MT write is dropped.
- `abortE` in RUN or FIX returns the unit to IDLE on the next edge. HI/LO are left unchanged. `abortE` in IDLE has no effect, except that it blocks a start sampled in the same cycle.
- Asserting `reset` mid-operation immediately clears all state and registers.

## Timing
- Start is sampled at edge 0. `mdrunE` is high from edge 0 through edge 33 (32 RUN cycles plus 1 FIX cycle), so it is high for 33 cycles.
- HI/LO are updated at edge 33, when `mdrunE` falls. An MFHI/MFLO in the following cycle sees the new values.
- `hilooutE` has zero-cycle latency from `hiloselE`.
- MT writes are visible on `hilooutE` in the cycle after the write edge.

## Configuration
- `MDU_FAST_MULT_EN` defined:
  - MULT/MULTU skip RUN and go from IDLE directly to FIX, using a combinational WIDTH×WIDTH product; `mdrunE` is high for 1 cycle.
  - Divide is unchanged.
- `MDU_FAST_MULT_EN` undefined: all operations take 33 cycles, and no hardware multiplier is inferred.

## Structure
- Shared package `mdu_pkg`:
  - state enum (IDLE/RUN/FIX)
  - `mdopE` field encodings (MD_DIV bit, MD_UNS bit)
  - `MDU_ITER`=32
  - `WIDTH` default
- One sub-module, `mdu_step`: a combinational single-iteration datapath for both the shift-add step and the restoring-divide step, selected by the div bit. The top level holds the FSM, counter, sign fixup and HI/LO.

## Test plan
- MULT signed 0xFFFFFFFE × 0x00000003, hold, check timing and result:
  - `mdrunE` stays high 33 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - With `MDU_FAST_MULT_EN`: the same result with `mdrunE` high 1 cycle.
- Divide results:
  - DIV -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 0x10: LO=0x0FFFFFFF, HI=0xF.
- Divide-by-zero and overflow corners:
  - DIVU 0x1234 / 0: LO=0xFFFFFFFF, HI=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A in IDLE: `hilooutE` reads each back per `hiloselE`. The same strobes issued while busy leave HI/LO unchanged.
- Start MULTU, then pulse `abortE` at cycle 10: `mdrunE` falls the next cycle and HI/LO keep their prior values. A back-to-back start afterwards completes normally.
- Drop `reset` mid-DIV at cycle 20: `mdrunE`=0 immediately and HI=LO=0. After release, a new DIV completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// mdopE field positions and iteration parameters.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_ITER  = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_ITER);

    // Bit positions inside mdopE
    localparam int unsigned MD_DIV = 0;
    localparam int unsigned MD_UNS = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath: shift-add multiply step or
// restoring divide step on a packed {hi, lo} accumulator, chosen by div_i.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             nonneg;

    always_comb begin
        // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        nonneg  = shifted >= {1'b0, opnd_i};
        diff    = shifted[WIDTH-1:0] - opnd_i;
        if (div_i) begin
            acc_o = {(nonneg ? diff : shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], nonneg};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MT/MF access.
// Define MDU_FAST_MULT_EN to compute multiplies in a single FIX cycle.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic [1:0]       mdopE,
    input  logic             hilowriteE,
    input  logic             hiloselE,
    input  logic             abortE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             mdrunE,
    output logic [WIDTH-1:0] hilooutE
);

    mdu_state_e state_q, state_d;

    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 div_q, div_d;
    logic                 neg_prod_q, neg_prod_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 start;
    logic                 mt_we;
    logic                 commit;
    logic                 fast_mult;
    logic [2*WIDTH-1:0]   step_acc;

    logic                 sgn, neg_a, neg_b;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   res, prod;

`ifdef MDU_FAST_MULT_EN
    assign fast_mult = ~mdopE[MD_DIV];
`else
    assign fast_mult = 1'b0;
`endif

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = fast_mult ? StFix : StRun;
            StRun: begin
                if (abortE) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mdrunE = (state_q != StIdle);
        start  = (state_q == StIdle) && mdstartE && !abortE;
        // A start in the same cycle drops the MT write, even when abort blocks the start.
        mt_we  = (state_q == StIdle) && hilowriteE && !mdstartE;
        commit = (state_q == StFix) && !abortE;
    end

    always_comb begin
        sgn   = ~mdopE[MD_UNS];
        neg_a = sgn & srcaE[WIDTH-1];
        neg_b = sgn & srcbE[WIDTH-1];
        abs_a = neg_a ? -srcaE : srcaE;
        abs_b = neg_b ? -srcbE : srcbE;

        res = acc_q;
`ifdef MDU_FAST_MULT_EN
        if (!div_q) begin
            res = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        end
`endif
        prod = neg_prod_q ? -res : res;
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        div_d      = div_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        if (start) begin
            div_d      = mdopE[MD_DIV];
            neg_prod_d = neg_a ^ neg_b;
            neg_rem_d  = neg_a;
            // Multiply keeps the multiplicand aside; divide keeps the divisor aside.
            opnd_d     = mdopE[MD_DIV] ? abs_b : abs_a;
            acc_d      = {{WIDTH{1'b0}}, (mdopE[MD_DIV] ? abs_a : abs_b)};
            cnt_d      = MDU_CNT_W'(MDU_ITER - 1);
        end

        if (state_q == StRun) begin
            acc_d = step_acc;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (commit) begin
            if (div_q) begin
                lo_d = neg_prod_q ? -res[WIDTH-1:0] : res[WIDTH-1:0];
                hi_d = neg_rem_q ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH];
            end else begin
                lo_d = prod[WIDTH-1:0];
                hi_d = prod[2*WIDTH-1:WIDTH];
            end
        end

        if (mt_we) begin
            if (hiloselE) begin
                hi_d = srcaE;
            end else begin
                lo_d = srcaE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            div_q      <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            div_q      <= div_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign hilooutE = hiloselE ? hi_q : lo_q;

endmodule
